// File: rtl/exe_defs.sv
// -----------------------------------------------------------------------------
// exe_defs
// Shared definitions for the execute stage and its neighbours:
//   - ALU command codes (EXE_CMD)
//   - branch type codes (Branch_Type)
//   - bit positions inside the 2-bit MEM_Signal field
//   - the packed control word travelling down the pipeline
// -----------------------------------------------------------------------------
package exe_defs;

    typedef enum logic [3:0] {
        EXE_ADD = 4'b0000,
        EXE_SUB = 4'b0010,
        EXE_AND = 4'b0100,
        EXE_OR  = 4'b0101,
        EXE_NOR = 4'b0110,
        EXE_XOR = 4'b0111,
        EXE_SLL = 4'b1000,
        EXE_SRA = 4'b1001,
        EXE_SRL = 4'b1010
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_type_e;

    localparam int MEM_LOAD_BIT  = 1;
    localparam int MEM_STORE_BIT = 0;

    // Control word produced by decode and consumed downstream.
    typedef struct packed {
        logic       wb_en;
        logic [1:0] mem_signals;
        logic [1:0] branch_type;
        logic [3:0] exe_cmd;
        logic       is_imm;
    } exe_ctrl_t;

endpackage

// File: rtl/exe_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational WIDTH-bit ALU; wrap-around arithmetic, no flags.
// Ports:
//   EXE_CMD  in  4      ALU command (exe_defs::exe_cmd_e codes)
//   val1     in  WIDTH  first operand
//   val2     in  WIDTH  second operand; bits [4:0] are the shift amount
//   result   out WIDTH  ALU result, 0 for unassigned command codes
// -----------------------------------------------------------------------------
module alu
    import exe_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    output logic [WIDTH-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = val2[4:0];

    // Operation select; unassigned codes deliberately produce zero.
    always_comb begin
        result = '0;
        case (EXE_CMD)
            EXE_ADD: result = val1 + val2;
            EXE_SUB: result = val1 - val2;
            EXE_AND: result = val1 & val2;
            EXE_OR:  result = val1 | val2;
            EXE_NOR: result = ~(val1 | val2);
            EXE_XOR: result = val1 ^ val2;
            EXE_SLL: result = val1 << shamt_s;
            EXE_SRA: result = $signed(val1) >>> shamt_s;
            EXE_SRL: result = val1 >> shamt_s;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// Execute stage: runs the ALU, resolves branches, drives the redirect/flush
// toward IF/ID and owns the EX/MEM pipeline register. After a taken branch
// the next SHADOW advancing slots are squashed (wrong-path instructions).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   freeze              pipeline hold: no state change and no redirect
//   flushIn             incoming slot is a bubble
//   WB_ENin, MEM_SignalIn, Branch_TypeIn, EXE_CMDin   control from ID/EX
//   val1, val2, reg2_in, PCIn, destIn                 data from ID/EX
//   br_taken, br_addr, flushOut                       combinational redirect
//   WB_ENout, MEM_SignalOut, destOut, alu_result,
//   st_val, validOut                                  EX/MEM register
// -----------------------------------------------------------------------------
module exe_stage
    import exe_defs::*;
#(
    parameter int WIDTH  = 32,
    parameter int SHADOW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flushIn,
    input  logic             WB_ENin,
    input  logic [1:0]       MEM_SignalIn,
    input  logic [1:0]       Branch_TypeIn,
    input  logic [3:0]       EXE_CMDin,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] reg2_in,
    input  logic [WIDTH-1:0] PCIn,
    input  logic [4:0]       destIn,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_addr,
    output logic             flushOut,
    output logic             WB_ENout,
    output logic [1:0]       MEM_SignalOut,
    output logic [4:0]       destOut,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] st_val,
    output logic             validOut
);

    localparam logic [1:0] SHADOW_LOAD = 2'(SHADOW);

    logic [WIDTH-1:0] alu_res_s;
    logic             live_s;
    logic             cond_s;
    logic             br_taken_s;

    logic [1:0]       shadow_q, shadow_d;
    logic             valid_q, valid_d;
    logic             wb_en_q, wb_en_d;
    logic [1:0]       mem_q, mem_d;
    logic [4:0]       dest_q, dest_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] st_q, st_d;

    alu #(.WIDTH(WIDTH)) u_alu (
        .EXE_CMD (EXE_CMDin),
        .val1    (val1),
        .val2    (val2),
        .result  (alu_res_s)
    );

    // An instruction is live unless it is a bubble or sits in a branch shadow;
    // this also stops a branch inside the shadow from redirecting.
    assign live_s = !flushIn && (shadow_q == 2'd0);

    // Branch condition decode.
    always_comb begin
        cond_s = 1'b0;
        case (Branch_TypeIn)
            BR_BEZ:  cond_s = (val1 == '0);
            BR_BNE:  cond_s = (val1 != reg2_in);
            BR_JMP:  cond_s = 1'b1;
            default: cond_s = 1'b0;
        endcase
    end

    assign br_taken_s = live_s && !freeze && cond_s;

    // Shadow counter next state: load on redirect, count down every advancing
    // cycle (bubbles included), hold while frozen.
    always_comb begin
        shadow_d = shadow_q;
        if (freeze) begin
            shadow_d = shadow_q;
        end else if (br_taken_s) begin
            shadow_d = SHADOW_LOAD;
        end else if (shadow_q != 2'd0) begin
            shadow_d = shadow_q - 2'd1;
        end else begin
            shadow_d = 2'd0;
        end
    end

    // EX/MEM next state: control bits are masked by liveness, data loads as-is.
    always_comb begin
        valid_d = valid_q;
        wb_en_d = wb_en_q;
        mem_d   = mem_q;
        dest_d  = dest_q;
        res_d   = res_q;
        st_d    = st_q;
        if (freeze) begin
            valid_d = valid_q;
            wb_en_d = wb_en_q;
            mem_d   = mem_q;
            dest_d  = dest_q;
            res_d   = res_q;
            st_d    = st_q;
        end else begin
            valid_d = live_s;
            wb_en_d = WB_ENin & live_s;
            mem_d   = MEM_SignalIn & {2{live_s}};
            dest_d  = destIn;
            res_d   = alu_res_s;
            st_d    = reg2_in;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 2'd0;
            valid_q  <= 1'b0;
            wb_en_q  <= 1'b0;
            mem_q    <= 2'b00;
            dest_q   <= 5'd0;
            res_q    <= '0;
            st_q     <= '0;
        end else begin
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            wb_en_q  <= wb_en_d;
            mem_q    <= mem_d;
            dest_q   <= dest_d;
            res_q    <= res_d;
            st_q     <= st_d;
        end
    end

    // Output drive.
    always_comb begin
        br_taken      = br_taken_s;
        flushOut      = br_taken_s;
        br_addr       = PCIn + val2;
        validOut      = valid_q;
        WB_ENout      = wb_en_q;
        MEM_SignalOut = mem_q;
        destOut       = dest_q;
        alu_result    = res_q;
        st_val        = st_q;
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    localparam int W  = 32;
    localparam int SH = 2;

    logic          clk;
    logic          rst;
    logic          freeze;
    logic          flushIn;
    logic          WB_ENin;
    logic [1:0]    MEM_SignalIn;
    logic [1:0]    Branch_TypeIn;
    logic [3:0]    EXE_CMDin;
    logic [W-1:0]  val1, val2, reg2_in, PCIn;
    logic [4:0]    destIn;
    logic          br_taken, flushOut, WB_ENout, validOut;
    logic [W-1:0]  br_addr, alu_result, st_val;
    logic [1:0]    MEM_SignalOut;
    logic [4:0]    destOut;

    exe_stage #(.WIDTH(W), .SHADOW(SH)) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .flushIn       (flushIn),
        .WB_ENin       (WB_ENin),
        .MEM_SignalIn  (MEM_SignalIn),
        .Branch_TypeIn (Branch_TypeIn),
        .EXE_CMDin     (EXE_CMDin),
        .val1          (val1),
        .val2          (val2),
        .reg2_in       (reg2_in),
        .PCIn          (PCIn),
        .destIn        (destIn),
        .br_taken      (br_taken),
        .br_addr       (br_addr),
        .flushOut      (flushOut),
        .WB_ENout      (WB_ENout),
        .MEM_SignalOut (MEM_SignalOut),
        .destOut       (destOut),
        .alu_result    (alu_result),
        .st_val        (st_val),
        .validOut      (validOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: squash slots still pending plus the expected
    // contents of the EX/MEM slot.
    int          m_squash = 0;
    logic        m_valid = 1'b0, m_wb = 1'b0;
    logic [1:0]  m_mem = 2'b00;
    logic [4:0]  m_dest = 5'd0;
    logic [31:0] m_res = 32'd0, m_st = 32'd0;
    logic        e_live, e_taken;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            4'd0:    return a + b;
            4'd2:    return a - b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return ~(a | b);
            4'd7:    return a ^ b;
            4'd8:    return a << s;
            4'd9:    return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd10:   return a >> s;
            default: return 32'h0;
        endcase
    endfunction

    task automatic instr(input logic fl, input logic wb, input logic [1:0] mem, input logic [1:0] bt,
                         input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r2, input logic [31:0] pc, input logic [4:0] d);
        flushIn = fl; WB_ENin = wb; MEM_SignalIn = mem; Branch_TypeIn = bt;
        EXE_CMDin = cmd; val1 = a; val2 = b; reg2_in = r2; PCIn = pc; destIn = d;
    endtask

    // Check the combinational redirect against the model before the edge.
    task automatic pre();
        logic cond;
        #1;
        e_live = !flushIn && (m_squash == 0);
        case (Branch_TypeIn)
            2'b01:   cond = (val1 == 32'd0);
            2'b10:   cond = (val1 != reg2_in);
            2'b11:   cond = 1'b1;
            default: cond = 1'b0;
        endcase
        e_taken = e_live && !freeze && cond;
        chk("br_taken", 32'(br_taken), 32'(e_taken));
        chk("flushOut", 32'(flushOut), 32'(e_taken));
        if (e_taken) chk("br_addr", br_addr, PCIn + val2);
    endtask

    // Clock once, advance the model, compare the EX/MEM slot.
    task automatic post();
        @(posedge clk);
        #1;
        if (rst) begin
            m_squash = 0; m_valid = 1'b0; m_wb = 1'b0; m_mem = 2'b00;
            m_dest = 5'd0; m_res = 32'd0; m_st = 32'd0;
        end else if (!freeze) begin
            m_valid = e_live;
            m_wb    = WB_ENin && e_live;
            m_mem   = e_live ? MEM_SignalIn : 2'b00;
            m_dest  = destIn;
            m_res   = alu_ref(EXE_CMDin, val1, val2);
            m_st    = reg2_in;
            if (e_taken)           m_squash = SH;
            else if (m_squash > 0) m_squash = m_squash - 1;
        end
        chk("validOut",      32'(validOut),      32'(m_valid));
        chk("WB_ENout",      32'(WB_ENout),      32'(m_wb));
        chk("MEM_SignalOut", 32'(MEM_SignalOut), 32'(m_mem));
        chk("destOut",       32'(destOut),       32'(m_dest));
        chk("alu_result",    alu_result,         m_res);
        chk("st_val",        st_val,             m_st);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b1001, 32'h8000_0010, 32'd4,         32'hF800_0001};
        vecs[1]  = '{4'b1010, 32'h8000_0010, 32'd4,         32'h0800_0001};
        vecs[2]  = '{4'b0010, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[3]  = '{4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F};
        vecs[4]  = '{4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF};
        vecs[5]  = '{4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000};
        vecs[6]  = '{4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0};
        vecs[7]  = '{4'b1000, 32'd1,         32'h0000_003F, 32'h8000_0000};
        vecs[8]  = '{4'b1111, 32'h1234_5678, 32'd1,         32'h0000_0000};
        vecs[9]  = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
        vecs[10] = '{4'b0001, 32'd7,         32'd7,         32'h0000_0000};

        rst = 1'b1; freeze = 1'b0;
        instr(1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        post();
        chk("reset_valid", 32'(validOut), 32'd0);
        chk("reset_result", alu_result, 32'd0);
        rst = 1'b0;

        // ADD 5+7
        instr(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 32'd5, 32'd7, 32'd0, 32'd1, 5'd3);
        pre(); post();
        chk("add_result", alu_result, 32'd12);
        chk("add_dest", 32'(destOut), 32'd3);
        chk("add_wb", 32'(WB_ENout), 32'd1);
        chk("add_valid", 32'(validOut), 32'd1);

        // ALU vector table
        for (int i = 0; i < 11; i++) begin
            instr(1'b0, 1'b1, 2'b00, 2'b00, vecs[i].cmd, vecs[i].a, vecs[i].b, 32'd0, 32'd2, 5'(i));
            pre(); post();
            chk($sformatf("alu_vec%0d", i), alu_result, vecs[i].exp);
        end

        // BEZ taken, two squashed slots, third live
        instr(1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'h10, 5'd0);
        pre();
        chk("bez_taken", 32'(br_taken), 32'd1);
        chk("bez_flush", 32'(flushOut), 32'd1);
        chk("bez_addr", br_addr, 32'h0000_000C);
        post();
        instr(1'b0, 1'b1, 2'b10, 2'b00, 4'b0000, 32'd1, 32'd1, 32'd0, 32'h11, 5'd4);
        pre(); post();
        chk("sq1_valid", 32'(validOut), 32'd0);
        chk("sq1_wb", 32'(WB_ENout), 32'd0);
        chk("sq1_mem", 32'(MEM_SignalOut), 32'd0);
        instr(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 32'd1, 32'd2, 32'd0, 32'h12, 5'd5);
        pre(); post();
        chk("sq2_valid", 32'(validOut), 32'd0);
        chk("sq2_wb", 32'(WB_ENout), 32'd0);
        instr(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 32'd2, 32'd2, 32'd0, 32'h13, 5'd6);
        pre(); post();
        chk("live3_valid", 32'(validOut), 32'd1);
        chk("live3_result", alu_result, 32'd4);

        // BNE not taken, then JMP under freeze, then released
        instr(1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 32'd9, 32'd4, 32'd9, 32'h20, 5'd0);
        pre();
        chk("bne_nt", 32'(br_taken), 32'd0);
        post();
        chk("bne_valid", 32'(validOut), 32'd1);
        freeze = 1'b1;
        instr(1'b0, 1'b0, 2'b00, 2'b11, 4'b0000, 32'd1, 32'd8, 32'd0, 32'h21, 5'd7);
        pre();
        chk("jmp_frozen", 32'(br_taken), 32'd0);
        post();
        chk("frz_hold_result", alu_result, 32'd13);
        chk("frz_hold_valid", 32'(validOut), 32'd1);
        freeze = 1'b0;
        pre();
        chk("jmp_taken", 32'(br_taken), 32'd1);
        chk("jmp_addr", br_addr, 32'h29);
        post();
        // two bubbles drain the shadow
        instr(1'b1, 1'b0, 2'b00, 2'b00, 4'b0000, 32'd0, 32'd0, 32'd0, 32'h0, 5'd0);
        pre(); post();
        pre(); post();

        // BNE taken, JMP in first shadow slot is ignored
        instr(1'b0, 1'b0, 2'b00, 2'b10, 4'b0000, 32'd1, 32'd4, 32'd2, 32'h30, 5'd0);
        pre();
        chk("bne_taken", 32'(br_taken), 32'd1);
        post();
        instr(1'b0, 1'b0, 2'b00, 2'b11, 4'b0000, 32'd1, 32'd4, 32'd2, 32'h31, 5'd0);
        pre();
        chk("shadow_jmp", 32'(br_taken), 32'd0);
        post();
        chk("shadow_jmp_valid", 32'(validOut), 32'd0);
        instr(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 32'd1, 32'd1, 32'd0, 32'h32, 5'd1);
        pre(); post();
        chk("shadow2_valid", 32'(validOut), 32'd0);
        pre(); post();
        chk("after_shadow_valid", 32'(validOut), 32'd1);

        // ST as bubble
        instr(1'b1, 1'b0, 2'b01, 2'b00, 4'b0000, 32'd1, 32'd1, 32'd5, 32'h40, 5'd0);
        pre(); post();
        chk("st_bubble_mem", 32'(MEM_SignalOut), 32'd0);
        chk("st_bubble_valid", 32'(validOut), 32'd0);

        // Reset in the middle of a shadow
        instr(1'b0, 1'b0, 2'b00, 2'b11, 4'b0000, 32'd0, 32'd4, 32'd0, 32'h50, 5'd0);
        pre(); post();
        rst = 1'b1;
        instr(1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 32'd1, 32'd1, 32'd0, 32'h51, 5'd2);
        pre(); post();
        rst = 1'b0;
        pre(); post();
        chk("post_rst_valid", 32'(validOut), 32'd1);
        chk("post_rst_result", alu_result, 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rst    = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            instr(($urandom_range(0, 6) == 0), 1'($urandom), 2'($urandom), 2'($urandom),
                  4'($urandom), a, $urandom, ($urandom_range(0, 1) == 0) ? a : $urandom,
                  $urandom, 5'($urandom));
            pre(); post();
        end
        rst = 1'b0; freeze = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline; consumes the ID/EX register outputs produced by the decode stage.
- Performs the ALU operation and resolves branches.
- Drives the branch redirect and flush back toward IF/ID.
- Owns the EX/MEM pipeline register that feeds the memory stage.
- Squashes wrong-path instructions after a taken branch using an internal shadow counter.

Parameters:
- WIDTH, 32, datapath width of operands, PC and result.
- SHADOW, 2, number of advancing cycles after a taken branch whose arriving instructions are squashed (legal 0..3).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  pipeline hold (memory/hazard stall): no state changes, no redirect
- flushIn  in  1  incoming ID/EX slot is a bubble
- WB_ENin  in  1  write-back enable of the incoming instruction
- MEM_SignalIn  in  2  [1]=load, [0]=store
- Branch_TypeIn  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- EXE_CMDin  in  4  ALU command
- val1  in  WIDTH  first operand (rs)
- val2  in  WIDTH  second operand (rt or sign-extended immediate)
- reg2_in  in  WIDTH  rt value (store data, BNE compare)
- PCIn  in  WIDTH  PC of instruction + 1
- destIn  in  5  destination register
- br_taken  out  1  combinational branch redirect
- br_addr  out  WIDTH  redirect target
- flushOut  out  1  equals br_taken, to IF/ID
- WB_ENout  out  1  registered
- MEM_SignalOut  out  2  registered
- destOut  out  5  registered
- alu_result  out  WIDTH  registered
- st_val  out  WIDTH  registered
- validOut  out  1  registered, EX/MEM slot holds a live instruction

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: all registered outputs are 0; shadow counter is 0.
- live = !flushIn && (shadow_cnt == 0).
- ALU, combinational, WIDTH-bit, wrap-around, no flags:
  - 0000 ADD: val1+val2
  - 0010 SUB: val1-val2
  - 0100 AND
  - 0101 OR
  - 0110 NOR
  - 0111 XOR
  - 1000 SLL/SLA: val1<<val2[4:0]
  - 1001 SRA: arithmetic shift right
  - 1010 SRL: logical shift right
  - any other code: result 0
- Branch condition:
  - BEZ: val1==0
  - BNE: val1!=reg2_in
  - JMP: always
  - none: never
- br_addr = PCIn + val2 (word addressing). br_addr is always driven; its value is don't-care when br_taken=0.
- br_taken = live && !freeze && condition; combinational, same cycle.
- EX/MEM register, when !freeze:
  - validOut <= live
  - WB_ENout <= WB_ENin & live
  - MEM_SignalOut <= MEM_SignalIn & {2{live}}
  - destOut, alu_result <= ALU output, st_val <= reg2_in loaded unconditionally
- EX/MEM register, when freeze: all outputs hold.
- Branches never write back; WB_ENin from decode is already 0 for branches and is passed through unchanged.
- Shadow counter, evaluated only when !freeze:
  - br_taken: load SHADOW
  - else if shadow_cnt>0: decrement
  - else: hold at 0
- A branch arriving inside the shadow is itself squashed and cannot redirect.
- Back-to-back flushIn bubbles still decrement the counter.
- SHADOW=0: no squashing; IF/ID are responsible for flushing.
- freeze has priority over everything except rst.
- rst mid-shadow clears the counter; the first instruction after reset is live.

Decomposition:
- Package exe_defs holds:
  - EXE_CMD codes
  - Branch_Type codes
  - MEM_Signal bit indices
  - the shared {WB_En, Mem_Signals, Branch_Type, Exe_Cmd, isImm} control encoding
- Sub-module alu: combinational ALU, ports EXE_CMD, val1, val2, result.

Test Plan:
- Reset, then ADD with val1=5, val2=7, dest=3, WB_EN=1 → next cycle alu_result=12, destOut=3, WB_ENout=1, validOut=1.
- SRA with val1=0x80000010, val2=4 → 0xF8000001. SRL with the same operands → 0x08000001. SUB 3-5 → 0xFFFFFFFE.
- BEZ with val1=0, PCIn=0x10, val2=0xFFFFFFFC:
  - same cycle: br_taken=1, flushOut=1, br_addr=0x0C
  - next 2 instructions (LD, ADD) arrive with validOut=0, WB_ENout=0, MEM_SignalOut=00
  - third instruction is live
- BNE with val1=reg2_in=9 → br_taken=0, no squash. Then JMP while freeze=1 → br_taken=0 and outputs hold; freeze drops → br_taken=1.
- Branch inside shadow: BNE taken, then a JMP in the first shadow slot → JMP yields no br_taken; counter continues from 1 to 0.
- ST with flushIn=1 → MEM_SignalOut=00. rst asserted while shadow_cnt=2 → next live ADD produces validOut=1.
